// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, reset vector and the fetch bundle
// handed from the fetch stage to decode.
package cpu_pkg;

  localparam int unsigned     XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of fetch bundles between instr_mem and decode.
// Flush empties the queue in one cycle and wins over push/pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_t        push_data,
  input  logic          pop,
  output fetch_t        head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  // Storage, pointers and occupancy; flush only resets the bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instr_mem read per cycle while the
// output queue has room, tags each read with an epoch so reads overtaken by a
// redirect are dropped, and presents {pc, instr} to decode.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            busy
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 2);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag_pc;
  logic            tag_epoch;
  logic            epoch;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occupied;
  logic [CW-1:0]   limit;
  logic            pop;
  logic            issue;
  logic            resp_push;
  fetch_t          head;
  fetch_t          resp;

  // A slot is free when queued plus in-flight entries stay below the depth,
  // counting the entry decode takes this cycle as already gone.
  assign pop       = out_valid & out_ready;
  assign occupied  = count + CW'(inflight);
  assign limit     = CW'(BUF_DEPTH) + CW'(pop);
  assign issue     = rst_n & ~redirect_valid & ~halt_req & (occupied < limit);
  // A response landing in a redirect cycle belongs to the old path.
  assign resp_push = inflight & (tag_epoch == epoch) & ~redirect_valid;
  assign resp      = '{pc: tag_pc, instr: imem_instr};

  assign imem_en   = issue;
  assign imem_addr = {2'b00, pc[XLEN-1:2]};
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign busy      = inflight | (count != '0);

  // PC, epoch and the tag of the read currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      epoch     <= 1'b0;
      tag_pc    <= '0;
      tag_epoch <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        epoch <= ~epoch;
        pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (issue) begin
        pc        <= pc + XLEN'(4);
        tag_pc    <= pc;
        tag_epoch <= epoch;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (resp_push),
    .push_data (resp),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized run, with a
// scoreboard that predicts the instruction stream decode must see.
module tb_instr_fetch_ctrl;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        busy;

  int total = 0;
  int bad = 0;
  int pops = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .busy           (busy)
  );

  // Memory contents are a hash of the word address so wrong words are visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // instr_mem: one-cycle registered read.
  always @(posedge clk) if (imem_en) imem_instr <= mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode sees an unbroken sequence of word-aligned PCs
  // starting at the reset vector or the latest redirect target.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc = RESET_PC;

  function automatic void model_restart(input logic [31:0] p);
    exp_q.delete();
    next_pc = {p[31:2], 2'b00};
  endfunction

  function automatic void model_fill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{next_pc, mem_word(next_pc >> 2)});
      next_pc = next_pc + 32'd4;
    end
  endfunction

  // Monitor: compare every accepted bundle, and police queue overflow.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dut.resp_push)
        check("push_into_full", {31'b0, (int'(dut.count) == DEPTH) && !(out_valid && out_ready)}, 32'd0);
      if (out_valid && out_ready && !redirect_valid) begin
        model_fill();
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        pops++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous assert between edges; release one cycle-aligned step later.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    model_restart(RESET_PC);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_imem_en", {31'b0, imem_en}, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC >> 2);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int issues;
    int got;
    int halt_left;
    cyc();

    // Streaming after reset: one fetch per cycle, output from cycle 2.
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stream_en", {31'b0, imem_en}, 32'd1);
      check("stream_addr", imem_addr, c);
      check("stream_valid", {31'b0, out_valid}, {31'b0, c >= 2});
      if (c >= 2) begin
        check("stream_pc", out_pc, 4 * (c - 2));
        check("stream_instr", out_instr, mem_word(c - 2));
      end
      cyc();
    end

    // Backpressure: queue fills, head held, no issue while full.
    out_ready = 1'b0;
    do_reset();
    issues = 0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      issues += int'(imem_en);
      if (out_valid) got = 1;
      cyc();
    end
    check("bp_first_valid", got, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      issues += int'(imem_en);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_pc_held", out_pc, 32'd0);
      check("bp_no_issue", {31'b0, imem_en}, 32'd0);
      cyc();
    end
    check("bp_issue_count", issues, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_resume_valid", {31'b0, out_valid}, 32'd1);
      check("bp_resume_pc", out_pc, 4 * k);
      cyc();
    end

    // Redirect to 0x20 (low bits set, must be ignored) while pc=0x0C.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0022;
    model_restart(redirect_pc);
    @(negedge clk);
    check("rd_pc_before", imem_addr, 32'd3);
    check("rd_no_issue", {31'b0, imem_en}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_target_addr", imem_addr, 32'd8);
    check("rd_target_en", {31'b0, imem_en}, 32'd1);
    check("rd_gap1", {31'b0, out_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("rd_gap2", {31'b0, out_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("rd_target_valid", {31'b0, out_valid}, 32'd1);
    check("rd_target_pc", out_pc, 32'h20);
    check("rd_target_instr", out_instr, mem_word(32'd8));
    cyc();

    // Halt for 4 cycles mid-stream, then resume at the next sequential PC.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cyc();
    end
    halt_req = 1'b1;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      check("halt_no_issue", {31'b0, imem_en}, 32'd0);
      if (h == 3) begin
        check("halt_busy", {31'b0, busy}, 32'd0);
        check("halt_drained", {31'b0, out_valid}, 32'd0);
      end
      cyc();
    end
    halt_req = 1'b0;
    @(negedge clk);
    check("resume_en", {31'b0, imem_en}, 32'd1);
    check("resume_addr", imem_addr, 32'h34 >> 2);
    cyc();
    @(negedge clk);
    check("resume_gap", {31'b0, out_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("resume_valid", {31'b0, out_valid}, 32'd1);
    check("resume_pc", out_pc, 32'h34);
    cyc();

    // Redirect near the top of the address space: PC wraps to 0.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    model_restart(redirect_pc);
    @(negedge clk);
    cyc();
    redirect_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wrap_valid", {31'b0, out_valid}, 32'd1);
      check("wrap_pc", out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      check("wrap_instr", out_instr, mem_word((32'hFFFF_FFF8 + 32'(4 * k)) >> 2));
      cyc();
    end

    // Reset with a full queue: outputs clear at once, restart from RESET_PC.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cyc();
    end
    check("full_before_reset", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    do_reset();
    got = -1;
    for (int c = 0; c < 6 && got < 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got = c;
        check("post_rst_pc", out_pc, RESET_PC);
      end
      cyc();
    end
    check("post_rst_latency", got, 2);

    // Randomized traffic against the scoreboard.
    halt_left = 0;
    for (int n = 0; n < 800; n++) begin
      out_ready = ($urandom % 4) != 0;
      if (halt_left > 0) halt_left--;
      else if ($urandom % 30 == 0) halt_left = $urandom_range(1, 6);
      halt_req = (halt_left > 0);
      if ($urandom % 20 == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom % 3 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom;
        model_restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      if ($urandom % 300 == 0) do_reset();
      @(negedge clk);
      cyc();
    end
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    check("sb_activity", {31'b0, pops > 200}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
